// File: rtl/alu_muldiv_sequencer_if.sv
// EX-stage bundle between the pipeline and the HI/LO mul/div sequencer.
// The pipeline drives the decoded instruction; the sequencer returns status.
interface alu_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [5:0]       instruction;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid, instruction, data1, data2, flush,
        input  result, busy, done, stall, hi, lo
    );

    modport slave (
        input  valid, instruction, data1, data2, flush,
        output result, busy, done, stall, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, with MF/MT access
// and a stall toward the pipeline while an operation is in flight.
module alu_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic                   clk,
    input logic                   reset,
    alu_muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   raw1;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic               busy_q;
    logic               done_q;

    logic               start;
    logic               read;
    logic               write;
    logic               sgn;
    logic               mul_op;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        start = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        if (bus.valid) begin
            unique case (bus.instruction)
                6'h18, 6'h19, 6'h1A, 6'h1B: start = 1'b1;
                6'h10, 6'h12:               read  = 1'b1;
                6'h11, 6'h13:               write = 1'b1;
                default: ;
            endcase
        end
    end

    assign sgn    = ~bus.instruction[0];
    assign mul_op = ~bus.instruction[1];
    assign abs1   = (sgn & bus.data1[WIDTH-1]) ? -bus.data1 : bus.data1;
    assign abs2   = (sgn & bus.data2[WIDTH-1]) ? -bus.data2 : bus.data2;

    // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                     + (acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            raw1   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (write) begin
                        if (bus.instruction[1]) lo_q <= bus.data1;
                        else                    hi_q <= bus.data1;
                    end
                    if (start && !bus.flush) begin
                        state  <= mul_op ? MUL : DIV;
                        cnt    <= CW'(WIDTH);
                        busy_q <= 1'b1;
                        is_div <= ~mul_op;
                        neg_q  <= sgn & (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
                        neg_r  <= sgn & bus.data1[WIDTH-1];
                        dz     <= ~mul_op & (bus.data2 == '0);
                        raw1   <= bus.data1;
                        opnd   <= mul_op ? abs1 : abs2;
                        acc    <= {{WIDTH{1'b0}}, (mul_op ? abs2 : abs1)};
                    end
                end
                MUL, DIV: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (state == MUL)
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        else
                            acc <= {(div_ge ? div_diff[WIDTH-1:0]
                                            : div_shift[WIDTH-1:0]),
                                    acc[WIDTH-2:0], div_ge};
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (is_div) begin
                            lo_q <= dz ? '1 : quo;
                            hi_q <= dz ? raw1 : rem;
                        end else begin
                            lo_q <= prod[WIDTH-1:0];
                            hi_q <= prod[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = read ? (bus.instruction[1] ? lo_q : hi_q) : '0;
    assign bus.stall  = busy_q & (start | read | write);
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Multi-cycle sequencer for the MIPS execute stage that runs MULT/MULTU/DIV/DIVU iteratively and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO.
- Asserts a stall toward the pipeline whenever an HI/LO-class instruction arrives while an operation is in flight.
- Sits beside the ALU in EX and receives the same funct field and operands as the ALU.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  EX-stage instruction is an R-type, not squashed.
- instruction  input  6  funct field.
- data1  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- data2  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  squash the in-flight operation (branch/exception).
- result  output  WIDTH  HI for MFHI, LO for MFLO, else 0; combinational from registers.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO take a new mul/div result.
- stall  output  1  freeze IF/ID/EX this cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, internal counter/accumulators=0; stall=0.
- Decode, only when valid=1:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU = start.
  - 0x10 MFHI, 0x12 MFLO = read.
  - 0x11 MTHI, 0x13 MTLO = write.
  - Any other funct is ignored.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start: latch operands.
  - Signed ops take magnitudes and record the quotient/product sign = sign(data1)^sign(data2) and the remainder sign = sign(data1).
  - Load counter = WIDTH.
  - Go to MUL or DIV.
  - busy goes 1 in the next cycle.
- MUL: one shift-add step per cycle over a 2*WIDTH accumulator; counter decrements; at counter==1 go to FIX.
- DIV: one restoring-division step per cycle; at counter==1 go to FIX.
- FIX: apply sign correction.
  - MUL: negate the 2*WIDTH product if negative.
  - DIV: negate the quotient/remainder per recorded signs.
  - Write hi/lo, go to IDLE.
  - done=1 in the cycle after the FIX edge.
- Latency: busy=1 for exactly WIDTH+1 cycles (32 iterations + FIX). New HI/LO are visible, with done=1, on cycle WIDTH+2 after the start edge.
- stall = valid & busy & (start|read|write), combinational.
  - A stalled instruction is not accepted; the pipeline re-presents it.
  - start arriving in the exact cycle done=1 is accepted (busy already 0).
- MTHI/MTLO when not busy: hi (or lo) <= data1 at the edge. MFHI/MFLO when not busy: result is the current register.
- Product: MULT is signed 64-bit and MULTU unsigned 64-bit; hi = upper WIDTH bits, lo = lower WIDTH bits.
- Division:
  - lo = quotient, hi = remainder, truncation toward zero.
  - Divisor 0, any variant: lo = all-ones, hi = data1 as presented; full latency, no exception.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- flush while busy:
  - Next state IDLE, busy=0.
  - hi/lo keep their pre-operation values; done stays 0.
- flush in IDLE coincident with start: flush wins, start is dropped.
- flush does not cancel an MT write in the same cycle. The pipeline must deassert valid for squashed instructions.
- reset mid-operation: same as power-on reset; hi/lo cleared.
- Counter never wraps: it is loaded only in IDLE and stops at FIX.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> busy 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle.
- MULT 0xFFFFFFFD(−3)×0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT started, MFLO presented at cycle 5 -> stall=1 through the last busy cycle. MFLO is accepted when done=1, with result = new lo.
- MTHI 0x12345678 in IDLE, then DIVU 9/4 with flush at cycle 10 -> busy drops next cycle, hi=0x12345678, no done. Next DIVU 9/4 -> lo=2, hi=1.
- reset asserted mid-DIV at cycle 20 -> next cycle busy=0, hi=lo=0, stall=0. A start on the following cycle runs the full 33-cycle latency.
